axis_insert_header_v2: RTL and testbench

- Parametrised AXI-Stream header inserter.
- Prepends 1..DATA_BYTE_WD header bytes to each input packet and realigns the payload across beats.
- Emits an extra flush beat when the residual bytes overflow the last beat.
- Full ready/valid backpressure on all three interfaces, with a registered output stage.
- Sits between the packet source and the downstream AXI-Stream sink. Provides a packet counter for status.

---
 rtl/axis_insert_header_v2_if.sv | 47 ++++
 rtl/axis_insert_header_v2.sv | 157 +++++++++++++++
 tb/tb_axis_insert_header_v2.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_insert_header_v2_if.sv
// Bundle of payload, header and output AXI-Stream signals.
// slave = inserter side, master = source/sink side.
interface axis_insert_header_v2_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int PKT_CNT_WD   = 16
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
  logic                    ready_insert;

  logic [PKT_CNT_WD-1:0]   pkt_cnt;

  modport slave (
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    output valid_out, data_out, keep_out, last_out,
    input  ready_out,
    input  valid_insert, data_insert, byte_insert_cnt,
    output ready_insert,
    output pkt_cnt
  );

  modport master (
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    input  valid_out, data_out, keep_out, last_out,
    output ready_out,
    output valid_insert, data_insert, byte_insert_cnt,
    input  ready_insert,
    input  pkt_cnt
  );
endinterface

// File: rtl/axis_insert_header_v2.sv
// Prepends 1..N header bytes to each AXI-Stream packet, realigning payload.
// Ports: clk, rst (async high), bus (payload in, header in, stream out, pkt_cnt).
module axis_insert_header_v2 #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int PKT_CNT_WD   = 16
) (
  input  logic clk,
  input  logic rst,
  axis_insert_header_v2_if.slave bus
);
  localparam int N  = DATA_BYTE_WD;
  localparam int CW = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [DATA_WD-1:0]    carry_q, carry_d;
  logic [CW-1:0]         hcnt_q, hcnt_d;
  logic [CW-1:0]         rem_q, rem_d;
  logic                  vld_q, vld_d;
  logic [DATA_WD-1:0]    data_q, data_d;
  logic [N-1:0]          keep_q, keep_d;
  logic                  last_q, last_d;
  logic [PKT_CNT_WD-1:0] pcnt_q, pcnt_d;

  logic                  load_ok;
  logic [DATA_WD-1:0]    data_m;
  int                    h, v, t, hi;

  function automatic logic [N-1:0] top_bits(input int k);
    top_bits = ~({N{1'b1}} >> k);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [N-1:0] k);
    for (int i = 0; i < N; i++) byte_mask[8*i +: 8] = {8{k[i]}};
  endfunction

  // Contiguous ones from the MSB; an empty keep counts as one byte.
  function automatic int lead_ones(input logic [N-1:0] k);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (run && k[i]) n++;
      else run = 1'b0;
    end
    lead_ones = (n == 0) ? 1 : n;
  endfunction

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    hcnt_d  = hcnt_q;
    rem_d   = rem_q;
    vld_d   = vld_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    pcnt_d  = pcnt_q;
    h       = int'(hcnt_q);
    v       = lead_ones(bus.keep_in);
    t       = h + v;
    hi      = int'(bus.byte_insert_cnt) + 1;
    load_ok = !vld_q || bus.ready_out;
    bus.ready_in     = 1'b0;
    bus.ready_insert = 1'b0;
    // Bytes past the valid tail are zeroed so they never leak out.
    data_m = bus.last_in ? (bus.data_in & byte_mask(top_bits(v)))
                         : bus.data_in;

    if (vld_q && bus.ready_out) begin
      vld_d  = 1'b0;
      data_d = '0;
      keep_d = '0;
      last_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        bus.ready_insert = 1'b1;
        if (bus.valid_insert) begin
          carry_d = bus.data_insert << (8 * (N - hi));
          hcnt_d  = CW'(hi);
          state_d = STREAM;
        end
      end
      STREAM: begin
        bus.ready_in = load_ok;
        if (bus.valid_in && load_ok) begin
          vld_d   = 1'b1;
          // A shift by the full width yields 0, so H=N passes carry only.
          data_d  = carry_q | (data_m >> (8 * h));
          carry_d = data_m << (8 * (N - h));
          keep_d  = '1;
          last_d  = 1'b0;
          if (bus.last_in) begin
            if (t <= N) begin
              keep_d  = top_bits(t);
              last_d  = 1'b1;
              pcnt_d  = pcnt_q + PKT_CNT_WD'(1);
              state_d = IDLE;
            end else begin
              rem_d   = CW'(t - N);
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (load_ok) begin
          vld_d   = 1'b1;
          data_d  = carry_q;
          keep_d  = top_bits(int'(rem_q));
          last_d  = 1'b1;
          pcnt_d  = pcnt_q + PKT_CNT_WD'(1);
          carry_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      carry_q <= '0;
      hcnt_q  <= '0;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      hcnt_q  <= hcnt_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign bus.valid_out = vld_q;
  assign bus.data_out  = data_q;
  assign bus.keep_out  = keep_q;
  assign bus.last_out  = last_q;
  assign bus.pkt_cnt   = pcnt_q;

endmodule

// File: tb/tb_axis_insert_header_v2.sv
// Testbench for axis_insert_header_v2 (N=4).
// Byte-queue reference model; directed and random packets.
module tb_axis_insert_header_v2;
  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [N-1:0]  k;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axis_insert_header_v2_if #(.DATA_WD(DW)) bus();

  axis_insert_header_v2 #(.DATA_WD(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    vectors    = 0;
  int    miscompares = 0;
  int    unstable   = 0;
  int    rdy_viol   = 0;
  int    rmode      = 0;
  int    ph         = 0;
  int    exp_pkts   = 0;
  beat_t obs[$];
  beat_t exp[$];
  beat_t held;
  logic  stall = 1'b0;

  // Downstream ready pattern: 0 always, 1 toggling 1,0,0,1, 2 random, 3 low.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: bus.ready_out = 1'b1;
      1: bus.ready_out = (ph % 4 == 0) || (ph % 4 == 3);
      2: bus.ready_out = 1'($urandom_range(0, 1));
      default: bus.ready_out = 1'b0;
    endcase
    ph++;
  end

  // Records accepted output beats and handshake-rule violations.
  always @(negedge clk) begin
    beat_t cur;
    cur = '{bus.data_out, bus.keep_out, bus.last_out};
    if (rst) begin
      stall <= 1'b0;
    end else begin
      if (stall && (!bus.valid_out || cur !== held))
        unstable <= unstable + 1;
      if (bus.valid_out && !bus.ready_out && bus.ready_in)
        rdy_viol <= rdy_viol + 1;
      if (bus.valid_out && bus.ready_out)
        obs.push_back(cur);
      stall <= bus.valid_out && !bus.ready_out;
      held  <= cur;
    end
  end

  task automatic send_header(input int h, input logic [DW-1:0] d);
    bit done;
    done = 0;
    bus.valid_insert    = 1'b1;
    bus.data_insert     = d;
    bus.byte_insert_cnt = 2'(h - 1);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (bus.ready_insert) done = 1;
      @(posedge clk);
      #1;
    end
    bus.valid_insert = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL header_timeout got no ready_insert want handshake");
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [N-1:0] k,
                           input logic l);
    bit done;
    done = 0;
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.keep_in  = k;
    bus.last_in  = l;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (bus.ready_in) done = 1;
      @(posedge clk);
      #1;
    end
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout got no ready_in want handshake");
    end
  endtask

  // Reference: output = header bytes then payload bytes, cut into N-byte beats.
  task automatic send_pkt(input int h, input logic [DW-1:0] hdr,
                          input logic [7:0] pay[$]);
    logic [7:0]    all[$];
    logic [DW-1:0] d;
    logic [N-1:0]  k;
    beat_t         b;
    for (int i = 0; i < h; i++) all.push_back(hdr[8*(h-1-i) +: 8]);
    foreach (pay[i]) all.push_back(pay[i]);
    for (int s = 0; s < all.size(); s += N) begin
      b = '0;
      for (int j = 0; j < N; j++)
        if (s + j < all.size()) begin
          b.d[DW-1-8*j -: 8] = all[s+j];
          b.k[N-1-j] = 1'b1;
        end
      b.l = (s + N >= all.size());
      exp.push_back(b);
    end
    exp_pkts++;
    send_header(h, hdr);
    for (int s = 0; s < pay.size(); s += N) begin
      d = $urandom;
      k = '0;
      for (int j = 0; j < N; j++)
        if (s + j < pay.size()) begin
          d[DW-1-8*j -: 8] = pay[s+j];
          k[N-1-j] = 1'b1;
        end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
      send_beat(d, k, s + N >= pay.size());
    end
  endtask

  task automatic wait_out(input int budget);
    for (int c = 0; c < budget && obs.size() < exp.size(); c++)
      @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.valid_in = 0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 0;
    bus.valid_insert = 0; bus.data_insert = '0; bus.byte_insert_cnt = '0;
    bus.ready_out = 1;
    #1 rst = 1'b1;
    #2;
    vectors++;
    if ({bus.valid_out, bus.last_out, bus.data_out, bus.keep_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_out got %b/%b/%h/%b want 0/0/0/0", bus.valid_out,
               bus.last_out, bus.data_out, bus.keep_out);
    end
    vectors++;
    if (bus.pkt_cnt !== 16'd0 || bus.ready_insert !== 1'b1 || bus.ready_in !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got cnt=%0d ri=%b rin=%b want 0/1/0",
               bus.pkt_cnt, bus.ready_insert, bus.ready_in);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_h2;
    obs.delete(); exp.delete();
    exp.push_back('{32'hCCDD0102, 4'b1111, 1'b0});
    exp.push_back('{32'h03040506, 4'b1111, 1'b1});
    exp_pkts++;
    send_header(2, 32'hAABBCCDD);
    send_beat(32'h01020304, 4'b1111, 0);
    send_beat(32'h05060708, 4'b1100, 1);
    wait_out(100);
    vectors++;
    if (obs.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL h2_count got %0d want %0d", obs.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL h2_beat%0d got %h/%b/%b want %h/%b/%b", i, obs[i].d,
                 obs[i].k, obs[i].l, exp[i].d, exp[i].k, exp[i].l);
      end
    end
    vectors++;
    if (bus.pkt_cnt !== 16'(exp_pkts)) begin
      miscompares++;
      $display("FAIL h2_pkt_cnt got %0d want %0d", bus.pkt_cnt, exp_pkts);
    end
  endtask

  task automatic test_h3_flush;
    obs.delete(); exp.delete();
    exp.push_back('{32'h223344A1, 4'b1111, 1'b0});
    exp.push_back('{32'hA2A30000, 4'b1100, 1'b1});
    exp_pkts++;
    send_header(3, 32'h11223344);
    send_beat(32'hA1A2A3A4, 4'b1110, 1);
    wait_out(100);
    vectors++;
    if (obs.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL h3_count got %0d want %0d", obs.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL h3_beat%0d got %h/%b/%b want %h/%b/%b", i, obs[i].d,
                 obs[i].k, obs[i].l, exp[i].d, exp[i].k, exp[i].l);
      end
    end
  endtask

  task automatic test_h4_full;
    obs.delete(); exp.delete();
    exp.push_back('{32'hDEADBEEF, 4'b1111, 1'b0});
    exp.push_back('{32'h01000000, 4'b1000, 1'b1});
    exp_pkts++;
    send_header(4, 32'hDEADBEEF);
    send_beat(32'h01020304, 4'b1000, 1);
    wait_out(100);
    vectors++;
    if (obs.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL h4_count got %0d want %0d", obs.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL h4_beat%0d got %h/%b/%b want %h/%b/%b", i, obs[i].d,
                 obs[i].k, obs[i].l, exp[i].d, exp[i].k, exp[i].l);
      end
    end
    vectors++;
    if (bus.pkt_cnt !== 16'(exp_pkts)) begin
      miscompares++;
      $display("FAIL h4_pkt_cnt got %0d want %0d", bus.pkt_cnt, exp_pkts);
    end
  endtask

  task automatic test_backpressure;
    obs.delete(); exp.delete();
    unstable = 0; rdy_viol = 0;
    rmode = 1;
    exp.push_back('{32'hCCDD0102, 4'b1111, 1'b0});
    exp.push_back('{32'h03040506, 4'b1111, 1'b1});
    exp_pkts++;
    send_header(2, 32'hAABBCCDD);
    send_beat(32'h01020304, 4'b1111, 0);
    send_beat(32'h05060708, 4'b1100, 1);
    wait_out(100);
    rmode = 0;
    vectors++;
    if (obs.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL bp_count got %0d want %0d", obs.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL bp_beat%0d got %h/%b/%b want %h/%b/%b", i, obs[i].d,
                 obs[i].k, obs[i].l, exp[i].d, exp[i].k, exp[i].l);
      end
    end
    vectors++;
    if (unstable !== 0 || rdy_viol !== 0) begin
      miscompares++;
      $display("FAIL bp_stable got unstable=%0d rdy_viol=%0d want 0/0",
               unstable, rdy_viol);
    end
  endtask

  task automatic test_back_to_back;
    obs.delete(); exp.delete();
    exp.push_back('{32'hCCDD0102, 4'b1111, 1'b0});
    exp.push_back('{32'h03040506, 4'b1111, 1'b1});
    exp.push_back('{32'h223344A1, 4'b1111, 1'b0});
    exp.push_back('{32'hA2A30000, 4'b1100, 1'b1});
    send_header(2, 32'hAABBCCDD);
    send_beat(32'h01020304, 4'b1111, 0);
    bus.valid_insert    = 1'b1;
    bus.data_insert     = 32'h11223344;
    bus.byte_insert_cnt = 2'd2;
    #1;
    vectors++;
    if (bus.ready_insert !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_hold got ready_insert=%b want 0", bus.ready_insert);
    end
    send_beat(32'h05060708, 4'b1100, 1);
    exp_pkts++;
    #1;
    vectors++;
    if (bus.ready_insert !== 1'b1 || bus.pkt_cnt !== 16'(exp_pkts)) begin
      miscompares++;
      $display("FAIL b2b_idle got ri=%b cnt=%0d want 1/%0d",
               bus.ready_insert, bus.pkt_cnt, exp_pkts);
    end
    send_header(3, 32'h11223344);
    send_beat(32'hA1A2A3A4, 4'b1110, 1);
    exp_pkts++;
    wait_out(100);
    vectors++;
    if (obs.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL b2b_count got %0d want %0d", obs.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL b2b_beat%0d got %h/%b/%b want %h/%b/%b", i, obs[i].d,
                 obs[i].k, obs[i].l, exp[i].d, exp[i].k, exp[i].l);
      end
    end
    vectors++;
    if (bus.pkt_cnt !== 16'(exp_pkts)) begin
      miscompares++;
      $display("FAIL b2b_pkt_cnt got %0d want %0d", bus.pkt_cnt, exp_pkts);
    end
  endtask

  task automatic test_reset_flush;
    obs.delete(); exp.delete();
    rmode = 3;
    @(posedge clk);
    #1;
    send_header(3, 32'h11223344);
    send_beat(32'hA1A2A3A4, 4'b1110, 1);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.valid_out, bus.last_out, bus.data_out, bus.keep_out} !== '0) begin
      miscompares++;
      $display("FAIL rstfl_out got %b/%b/%h/%b want 0/0/0/0", bus.valid_out,
               bus.last_out, bus.data_out, bus.keep_out);
    end
    vectors++;
    if (bus.ready_insert !== 1'b1 || bus.pkt_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rstfl_state got ri=%b cnt=%0d want 1/0",
               bus.ready_insert, bus.pkt_cnt);
    end
    exp_pkts = 0;
    rmode = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    obs.delete();
    exp.push_back('{32'hCCDD0102, 4'b1111, 1'b0});
    exp.push_back('{32'h03040506, 4'b1111, 1'b1});
    exp_pkts++;
    send_header(2, 32'hAABBCCDD);
    send_beat(32'h01020304, 4'b1111, 0);
    send_beat(32'h05060708, 4'b1100, 1);
    wait_out(100);
    vectors++;
    if (obs.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL rstfl_count got %0d want %0d", obs.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL rstfl_beat%0d got %h/%b/%b want %h/%b/%b", i, obs[i].d,
                 obs[i].k, obs[i].l, exp[i].d, exp[i].k, exp[i].l);
      end
    end
    vectors++;
    if (bus.pkt_cnt !== 16'(exp_pkts)) begin
      miscompares++;
      $display("FAIL rstfl_pkt_cnt got %0d want %0d", bus.pkt_cnt, exp_pkts);
    end
  endtask

  task automatic test_random;
    logic [7:0] pay[$];
    obs.delete(); exp.delete();
    unstable = 0; rdy_viol = 0;
    rmode = 2;
    for (int p = 0; p < 40; p++) begin
      pay.delete();
      repeat ($urandom_range(1, 13)) pay.push_back(8'($urandom));
      send_pkt($urandom_range(1, N), $urandom, pay);
    end
    wait_out(3000);
    rmode = 0;
    vectors++;
    if (obs.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL rand_count got %0d want %0d", obs.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL rand_beat%0d got %h/%b/%b want %h/%b/%b", i, obs[i].d,
                 obs[i].k, obs[i].l, exp[i].d, exp[i].k, exp[i].l);
      end
    end
    vectors++;
    if (bus.pkt_cnt !== 16'(exp_pkts)) begin
      miscompares++;
      $display("FAIL rand_pkt_cnt got %0d want %0d", bus.pkt_cnt, exp_pkts);
    end
    vectors++;
    if (unstable !== 0 || rdy_viol !== 0) begin
      miscompares++;
      $display("FAIL rand_stable got unstable=%0d rdy_viol=%0d want 0/0",
               unstable, rdy_viol);
    end
  endtask

  initial begin
    test_reset();
    test_h2();
    test_h3_flush();
    test_h4_full();
    test_backpressure();
    test_back_to_back();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
